// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: registered N-way operand selector with valid/ready handshake and transfer counter
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_data[N_IN*WIDTH]      packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel, in_valid         select code and upstream valid, sampled together
//   in_ready                 stage can accept this cycle
//   out_data, out_sel        registered operand and the select code it came from
//   out_valid, out_ready     output handshake
//   xfer_cnt                 wrapping count of delivered operands
//   sel_err                  sticky out-of-range select flag (only with OPERAND_SEL_ERR_EN)
module operand_sel_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      xfer_cnt
`ifdef OPERAND_SEL_ERR_EN
    ,
    output logic                  sel_err
`endif
);
    generate
        if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
            $error("operand_sel_pipe: N_IN must be in 2..16");
        end
        if ((1 << SEL_W) < N_IN) begin : g_bad_sel_w
            $error("operand_sel_pipe: SEL_W too narrow for N_IN");
        end
    endgenerate
    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;
    logic             accept;
    logic             deliver;
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            if (accept) begin
                out_data <= sel_hit ? sel_data : '0;
                out_sel  <= in_sel;
            end
            out_valid <= accept ? 1'b1 : (deliver ? 1'b0 : out_valid);
            if (deliver)
                xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`ifdef OPERAND_SEL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_err <= 1'b0;
        else if (accept && !sel_hit)
            sel_err <= 1'b1;
    end
`else
    // out-of-range selects are zeroed silently, no error state kept
`endif
endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb_operand_sel_pipe: scoreboard bench for operand_sel_pipe (WIDTH=8, N_IN=3, SEL_W=2, CNT_W=4)
module tb_operand_sel_pipe;
    localparam int WIDTH = 8;
    localparam int N_IN  = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;
    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } exp_t;
    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N_IN*WIDTH-1:0] in_data = '0;
    logic [SEL_W-1:0]      in_sel = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [CNT_W-1:0]      xfer_cnt;
`ifdef OPERAND_SEL_ERR_EN
    logic                  sel_err;
`endif
    exp_t             q[$];
    logic             mv = 1'b0;
    logic [CNT_W-1:0] cnt_m = '0;
    logic             err_m = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    operand_sel_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
`ifdef OPERAND_SEL_ERR_EN
        , .sel_err(sel_err)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [WIDTH-1:0] sel_model(input logic [N_IN*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        return (int'(s) < N_IN) ? d[int'(s)*WIDTH +: WIDTH] : '0;
    endfunction
    // one clock cycle: check state left by the previous edge, drive, predict the next edge
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic r, input logic [N_IN*WIDTH-1:0] d);
        logic rdy;
        exp_t e;
        @(posedge clk);
        #1;
        check("out_valid", out_valid, mv);
        check("xfer_cnt", xfer_cnt, cnt_m);
`ifdef OPERAND_SEL_ERR_EN
        check("sel_err", sel_err, err_m);
`endif
        in_valid = v; in_sel = s; out_ready = r; in_data = d;
        #1;
        rdy = !mv || r;
        check("in_ready", in_ready, rdy);
        if (mv && !r && q.size() > 0)
            check("stall_data", out_data, q[0].d);
        if (mv && r) begin
            if (q.size() == 0) begin
                check("queue_empty", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.d);
                check("out_sel", out_sel, e.s);
            end
            cnt_m = cnt_m + 1'b1;
        end
        if (v && rdy) begin
            q.push_back(exp_t'({sel_model(d, s), s}));
            if (int'(s) >= N_IN) err_m = 1'b1;
        end
        mv = (v && rdy) ? 1'b1 : ((mv && r) ? 1'b0 : mv);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
`ifdef OPERAND_SEL_ERR_EN
        check("rst_sel_err", sel_err, 0);
`endif
        q.delete();
        mv = 1'b0; cnt_m = '0; err_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        logic [N_IN*WIDTH-1:0] d;
        d = 24'h332211;
        do_reset();
        step(1, 0, 1, d);
        step(1, 1, 1, d);
        step(1, 2, 1, d);
        step(1, 3, 1, d);
        step(0, 0, 1, d);
        step(0, 0, 1, d);
        check("sweep_cnt", xfer_cnt, 4);
`ifdef OPERAND_SEL_ERR_EN
        check("sweep_sel_err", sel_err, 1);
`endif
        step(1, 1, 1, d);
        step(0, 0, 0, 24'hCCBBAA);
        step(1, 2, 0, 24'h445566);
        step(1, 0, 0, 24'h778899);
        check("bp_hold_data", out_data, 8'h22);
        step(0, 0, 1, d);
        step(0, 0, 1, d);
        check("bp_cnt", xfer_cnt, 5);
        step(1, 1, 1, d);
        step(1, 0, 1, 24'h0000A5);
        step(0, 0, 1, d);
        check("simul_data", out_data, 8'hA5);
        check("simul_valid", out_valid, 1);
        step(0, 0, 1, d);
        do_reset();
        for (int i = 0; i < 17; i++)
            step(1, SEL_W'(i % 4), 1, N_IN*WIDTH'($urandom));
        step(0, 0, 1, d);
        step(0, 0, 1, d);
        check("wrap_end", xfer_cnt, 1);
        step(1, 1, 1, d);
        step(0, 0, 0, d);
        do_reset();
        step(1, 2, 1, d);
        step(0, 0, 1, d);
        step(0, 0, 1, d);
        check("post_rst_cnt", xfer_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
